// File: rtl/memory_pkg.sv
// Shared widths and helpers for the tiny16 word memory.
package memory_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  // Index width for an array of `size` words; never narrower than one bit.
  function automatic int idx_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/memory_if.sv
// Internal-bus view of the word memory: address load, write and read strobes.
interface memory_if;
  import memory_pkg::*;

  logic              addr_en;
  logic [ADDR_W-1:0] addr;
  logic              in_en;
  logic [WORD_W-1:0] in;
  logic              out_en;
  logic [WORD_W-1:0] out;

  modport master (
    output addr_en, addr, in_en, in, out_en,
    input  out
  );

  modport slave (
    input  addr_en, addr, in_en, in, out_en,
    output out
  );

endinterface

// File: rtl/memory_array.sv
// Synchronous-write, synchronous-read word RAM with no reset so it maps to block RAM.
module memory_array
  import memory_pkg::*;
#(
  parameter int MEM_SIZE = 65536
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int IDX_W = idx_width(MEM_SIZE);

  logic [WORD_W-1:0] mem [MEM_SIZE];
  logic [IDX_W-1:0]  idx;

  // Addresses past the end wrap around; a no-op when MEM_SIZE is 65536.
  assign idx = IDX_W'(32'(addr) % MEM_SIZE);

  // Non-blocking read and write on the same edge give read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata    <= mem[idx];
  end

endmodule

// File: rtl/memory.sv
// tiny16 main store: address register, enable decode and reset around memory_array.
module memory
  import memory_pkg::*;
#(
  parameter int MEM_SIZE = 65536
) (
  input  logic     clk,
  input  logic     rst,
  memory_if.slave  bus
);

  logic [ADDR_W-1:0] addr_reg;
  logic              out_valid;
  logic [WORD_W-1:0] rd_data;
  logic              we;
  logic              re;

  // A write on an edge that coincides with reset must not land.
  assign we = bus.in_en  & ~rst;
  assign re = bus.out_en & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (bus.addr_en) addr_reg  <= bus.addr;
      if (bus.out_en)  out_valid <= 1'b1;
    end
  end

  memory_array #(.MEM_SIZE(MEM_SIZE)) u_array (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .addr  (addr_reg),
    .wdata (bus.in),
    .rdata (rd_data)
  );

  // The RAM output register has no reset, so the async clear of the read
  // port is a flag that forces zero until the first read after reset.
  assign bus.out = out_valid ? rd_data : '0;

endmodule

// File: tb/tb_memory.sv
// Directed, table-driven checks for the tiny16 word memory.
module tb_memory;

  logic clk = 1'b0;
  logic rst = 1'b1;

  memory_if bus();

  memory #(.MEM_SIZE(65536)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        addr_en;
    logic [15:0] addr;
    logic        in_en;
    logic [15:0] in;
    logic        out_en;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: out=%h expected=%h", name, act, exp);
  endtask

  task automatic drive(input logic ae, input logic [15:0] a, input logic ie,
                       input logic [15:0] d, input logic oe);
    bus.addr_en = ae;
    bus.addr    = a;
    bus.in_en   = ie;
    bus.in      = d;
    bus.out_en  = oe;
  endtask

  task automatic add(input logic ae, input logic [15:0] a, input logic ie,
                     input logic [15:0] d, input logic oe, input logic [15:0] e);
    vec_t v;
    v.addr_en = ae; v.addr = a; v.in_en = ie; v.in = d; v.out_en = oe; v.exp_out = e;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset with garbage on the bus
    drive(1'b1, 16'hBEEF, 1'b1, 16'hDEAD, 1'b1);
    #2;
    check("reset_out_immediate", bus.out, 16'h0000);
    @(posedge clk); #1;
    check("reset_out_after_edge", bus.out, 16'h0000);
    @(posedge clk); #1;
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    #1 rst = 1'b0;

    // Uninitialised read, basic write/read, hold
    add(1, 16'h0040, 0, 16'h0000, 0, 16'h0000);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    add(0, 16'h0000, 1, 16'h1234, 0, 16'h0000);
    add(1, 16'h0001, 0, 16'h0000, 0, 16'h0000);
    add(0, 16'h0000, 1, 16'h4321, 0, 16'h0000);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h1234);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h1234);
    add(1, 16'h0001, 0, 16'h0000, 0, 16'h1234);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h4321);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h4321);
    // addr_en + in_en: write goes to old address 0
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h4321);
    add(1, 16'h0001, 1, 16'hABCD, 0, 16'h4321);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h4321);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'hABCD);
    add(1, 16'h0001, 0, 16'h0000, 0, 16'hABCD);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h4321);
    // Read-before-write at address 5
    add(1, 16'h0005, 0, 16'h0000, 0, 16'h4321);
    add(0, 16'h0000, 1, 16'h1111, 0, 16'h4321);
    add(0, 16'h0000, 1, 16'h2222, 1, 16'h1111);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h2222);
    // Boundary addresses, and read + address load together
    add(1, 16'hFFFF, 0, 16'h0000, 0, 16'h2222);
    add(0, 16'h0000, 1, 16'hFFFF, 0, 16'h2222);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h2222);
    add(0, 16'h0000, 1, 16'h0001, 0, 16'h2222);
    add(1, 16'hFFFF, 0, 16'h0000, 1, 16'h0001);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'hFFFF);
    add(1, 16'h7FFF, 0, 16'h0000, 1, 16'hFFFF);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h0001);

    foreach (vecs[i]) begin
      drive(vecs[i].addr_en, vecs[i].addr, vecs[i].in_en, vecs[i].in, vecs[i].out_en);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), bus.out, vecs[i].exp_out);
    end

    // Async reset between edges after a read
    drive(1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    check("pre_reset_read", bus.out, 16'h2222);
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", bus.out, 16'h0000);
    // Write attempted on an edge while reset is high must be dropped
    drive(1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b1);
    @(posedge clk); #1;
    check("reset_held_out", bus.out, 16'h0000);
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    // addr_reg cleared to 0, and mem[0] still holds 0001
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    check("post_reset_addr0", bus.out, 16'h0001);
    drive(1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("post_reset_hold", bus.out, 16'h0001);
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    check("post_reset_preserved", bus.out, 16'h2222);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
